// File: rtl/nn_mem_pkg.sv
// Shared constants and types for the neural block-memory node ports.
package nn_mem_pkg;

  localparam int unsigned NODES          = 16;
  localparam int unsigned NODE_W         = 16;
  localparam int unsigned ADDR_W         = 16;
  localparam int unsigned MEM_DEPTH_LOG2 = 11;
  localparam int unsigned CNT_W          = $clog2(NODES + 1);
  localparam int unsigned IDX_W          = $clog2(NODES);

  typedef logic [NODE_W-1:0] node_t;
  typedef node_t [NODES-1:0] node_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wb_state_t;

  // Clamp a requested node count to the vector size.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] cnt);
    return (cnt > CNT_W'(NODES)) ? CNT_W'(NODES) : cnt;
  endfunction

endpackage

// File: rtl/node_writeback.sv
// Serializes a captured node vector into single-word block-memory writes,
// yielding the data port to CPU stores whenever they are present.
module node_writeback
  import nn_mem_pkg::*;
(
  input  logic              iclk,
  input  logic              irst,
  input  logic              iStart,
  input  logic [ADDR_W-1:0] iBaseAddr,
  input  logic [CNT_W-1:0]  iCount,
  input  node_t             iNodes [NODES-1:0],
  input  logic              iCpuWrite,
  output logic              oReady,
  output logic              oBusy,
  output logic              oDataWrite,
  output logic [ADDR_W-1:0] oDataAddr,
  output logic [NODE_W-1:0] oData,
  output logic              oDone
);

  wb_state_t          state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  node_vec_t          buf_q, buf_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [NODE_W-1:0]  data_q, data_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               wr_c;
  logic [CNT_W-1:0]   req_cnt_c;
  logic [IDX_W-1:0]   idx_nxt_c;
  logic               last_c;

  // Port arbitration: a CPU store always wins the data port.
  assign wr_c = (state_q == WRITE) && !iCpuWrite;

  assign req_cnt_c = sat_count(iCount);
  assign idx_nxt_c = idx_q + IDX_W'(1);
  assign last_c    = (CNT_W'(idx_q) + CNT_W'(1)) == cnt_q;

  // Next-state, capture and write-pointer logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (iStart) begin
          cnt_d  = req_cnt_c;
          base_d = iBaseAddr;
          idx_d  = '0;
          for (int k = 0; k < int'(NODES); k++) begin
            buf_d[k] = iNodes[k];
          end
          addr_d  = iBaseAddr;
          data_d  = iNodes[0];
          state_d = (req_cnt_c == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (wr_c) begin
          idx_d  = idx_nxt_c;
          addr_d = base_q + ADDR_W'(idx_nxt_c);
          data_d = buf_q[idx_nxt_c];
          if (last_c) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they register cleanly.
  always_comb begin
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == WRITE);
    done_d  = (state_d == DONE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign oReady     = ready_q;
  assign oBusy      = busy_q;
  assign oDataWrite = wr_c;
  assign oDataAddr  = addr_q;
  assign oData      = data_q;
  assign oDone      = done_q;

endmodule

// File: tb/tb_node_writeback.sv
// Scoreboard bench for node_writeback: the driver predicts every write and
// done pulse with their cycle numbers; a negedge monitor checks them.
module tb_node_writeback;
  import nn_mem_pkg::*;

  logic              iclk = 1'b0;
  logic              irst;
  logic              iStart;
  logic [ADDR_W-1:0] iBaseAddr;
  logic [CNT_W-1:0]  iCount;
  node_t             iNodes [NODES-1:0];
  logic              iCpuWrite;
  logic              oReady, oBusy, oDataWrite, oDone;
  logic [ADDR_W-1:0] oDataAddr;
  logic [NODE_W-1:0] oData;

  node_writeback dut (
    .iclk(iclk), .irst(irst), .iStart(iStart), .iBaseAddr(iBaseAddr),
    .iCount(iCount), .iNodes(iNodes), .iCpuWrite(iCpuWrite),
    .oReady(oReady), .oBusy(oBusy), .oDataWrite(oDataWrite),
    .oDataAddr(oDataAddr), .oData(oData), .oDone(oDone)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t   wr_q [$];
  int    done_q [$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  logic [15:0] mem [0:(1<<MEM_DEPTH_LOG2)-1];

  always @(posedge iclk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write and done pulse must match the head of its queue.
  always @(negedge iclk) begin
    if (!irst) begin
      if (oDataWrite) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 32'(oDataAddr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("write_cycle", 32'(cyc), 32'(e.cyc));
          chk("write_addr", 32'(oDataAddr), 32'(e.addr));
          chk("write_data", 32'(oData), 32'(e.data));
        end
        mem[oDataAddr[MEM_DEPTH_LOG2-1:0]] = oData;
      end
      if (oDone) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          int ec;
          ec = done_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(ec));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(oReady), 32'd1);
    chk({tag, "_busy"}, 32'(oBusy), 32'd0);
    chk({tag, "_wr"}, 32'(oDataWrite), 32'd0);
    chk({tag, "_addr"}, 32'(oDataAddr), 32'd0);
    chk({tag, "_data"}, 32'(oData), 32'd0);
    chk({tag, "_done"}, 32'(oDone), 32'd0);
  endtask

  // One transfer. Inputs change at #1 after posedge. stall_mask bit j forces a
  // CPU store in the j-th cycle after accept; rnd_pct adds random stalls.
  // abort_after > 0 asserts reset right after that many writes.
  task automatic run_txn(input logic [15:0] base, input int cnt, input bit pat,
                         input logic [63:0] stall_mask, input int rnd_pct,
                         input int abort_after);
    node_t nv [NODES-1:0];
    int    n, sent, j;
    bit    stall;
    for (int k = 0; k < int'(NODES); k++)
      nv[k] = pat ? node_t'(16'h1000 + k) : node_t'($urandom);
    n = (cnt > int'(NODES)) ? int'(NODES) : cnt;

    chk("ready_before_start", 32'(oReady), 32'd1);
    iBaseAddr = base;
    iCount    = CNT_W'(cnt);
    for (int k = 0; k < int'(NODES); k++) iNodes[k] = nv[k];
    iStart    = 1'b1;
    iCpuWrite = 1'b0;
    @(posedge iclk); #1;

    // Inputs are free to change once accepted.
    iBaseAddr = 16'($urandom);
    iCount    = CNT_W'($urandom_range(20));
    for (int k = 0; k < int'(NODES); k++) iNodes[k] = node_t'($urandom);

    sent = 0;
    j = 0;
    while (sent < n && j < 1000) begin
      chk("busy_in_write", 32'(oBusy), 32'd1);
      chk("ready_in_write", 32'(oReady), 32'd0);
      chk("addr_valid", 32'(oDataAddr), 32'(16'(base + 16'(sent))));
      chk("data_valid", 32'(oData), 32'(nv[sent]));
      stall = (j < 64 && stall_mask[j]) || (int'($urandom_range(99)) < rnd_pct);
      iCpuWrite = stall;
      iStart    = ($urandom_range(3) == 0);
      if (!stall) begin
        wr_q.push_back('{cyc: cyc, addr: 16'(base + 16'(sent)), data: nv[sent]});
        sent++;
      end
      @(posedge iclk); #1;
      j++;
      if (abort_after > 0 && sent == abort_after) begin
        irst = 1'b1;
        iStart = 1'b0;
        iCpuWrite = 1'b0;
        wr_q.delete();
        done_q.delete();
        #1;
        check_reset_outputs("abort");
        @(posedge iclk); #1;
        irst = 1'b0;
        repeat (3) @(posedge iclk);
        #1;
        chk("ready_after_abort", 32'(oReady), 32'd1);
        return;
      end
    end
    if (j >= 1000) chk("write_budget", 32'(j), 32'(n));
    iStart    = 1'b0;
    iCpuWrite = 1'b0;
    done_q.push_back(cyc);
    chk("busy_in_done", 32'(oBusy), 32'd0);
    @(posedge iclk); #1;
    chk("ready_after_done", 32'(oReady), 32'd1);
    chk("done_seen", 32'(done_q.size()), 32'd0);
    chk("writes_drained", 32'(wr_q.size()), 32'd0);
  endtask

  initial begin
    irst = 1'b1;
    iStart = 1'b0;
    iBaseAddr = '0;
    iCount = '0;
    iCpuWrite = 1'b0;
    for (int k = 0; k < int'(NODES); k++) iNodes[k] = '0;
    repeat (2) @(posedge iclk);
    #1;
    check_reset_outputs("reset");
    irst = 1'b0;
    @(posedge iclk); #1;

    // Full vector, no stalls, then read back the written block.
    run_txn(16'h0100, 16, 1'b1, 64'd0, 0, 0);
    for (int k = 0; k < int'(NODES); k++)
      chk("node_read", 32'(mem[11'(16'h0100 + k)]), 32'(16'h1000 + k));

    // CPU stall over three cycles starting at the second write.
    run_txn(16'h0020, 4, 1'b0, 64'b1110, 0, 0);

    // Address wrap.
    run_txn(16'hFFFE, 3, 1'b0, 64'd0, 0, 0);

    // Zero-length request.
    run_txn(16'h0040, 0, 1'b0, 64'd0, 0, 0);

    // Reset after the fifth write, then a clean full transfer.
    run_txn(16'h0100, 16, 1'b1, 64'd0, 0, 5);
    run_txn(16'h0100, 16, 1'b1, 64'd0, 0, 0);

    // Count above the vector size saturates.
    run_txn(16'h0200, 20, 1'b0, 64'd0, 0, 0);

    // Random transfers with random CPU stalls.
    for (int t = 0; t < 25; t++)
      run_txn(16'($urandom), int'($urandom_range(20)), 1'b0, 64'd0, 30, 0);

    repeat (3) @(posedge iclk);
    #1;
    chk("final_write_queue", 32'(wr_q.size()), 32'd0);
    chk("final_done_queue", 32'(done_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
